// File: rtl/exe_pkg.sv
// exe_pkg: shared datapath width and alu_op encodings for the execute stage
package exe_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_XOR   = 4'h2;
  localparam logic [3:0] ALU_NOR   = 4'h3;
  localparam logic [3:0] ALU_ADD   = 4'h4;
  localparam logic [3:0] ALU_SUB   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_SLLV  = 4'hB;
  localparam logic [3:0] ALU_SRLV  = 4'hC;
  localparam logic [3:0] ALU_SRAV  = 4'hD;
  localparam logic [3:0] ALU_LUI   = 4'hE;
  localparam logic [3:0] ALU_PASSB = 4'hF;
endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU; overflow detection only when EXE_OVF_DETECT_EN is defined
module exe_alu #(
  parameter int XLEN = exe_pkg::XLEN,
  parameter int SHW = 5
) (
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow
);
  import exe_pkg::*;
  logic [XLEN-1:0] sum, diff;
  logic [SHW-1:0] vsh;
  assign sum = a + b;
  assign diff = a - b;
  assign vsh = a[SHW-1:0];
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_SLLV: result = b << vsh;
      ALU_SRLV: result = b >> vsh;
      ALU_SRAV: result = $unsigned($signed(b) >>> vsh);
      ALU_LUI:  result = {b[15:0], 16'h0};
      default:  result = b;
    endcase
  end
  assign zero = (result == '0);
`ifdef EXE_OVF_DETECT_EN
  assign overflow = (alu_op == ALU_ADD && a[XLEN-1] == b[XLEN-1] && sum[XLEN-1] != a[XLEN-1]) ||
                    (alu_op == ALU_SUB && a[XLEN-1] != b[XLEN-1] && diff[XLEN-1] != a[XLEN-1]);
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: rtl/exe_alu_branch_unit.sv
// exe_alu_branch_unit: registered ALU, branch target and beq/bne resolution; overflow gated by EXE_OVF_DETECT_EN
module exe_alu_branch_unit #(
  parameter int XLEN = exe_pkg::XLEN,
  parameter int SHW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_op,
  input  logic [SHW-1:0]  shamt,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] ext_imm,
  input  logic            branch_eq,
  input  logic            branch_ne,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow,
  output logic [XLEN-1:0] branch_target,
  output logic            pc_src,
  output logic            out_valid
);
  logic [XLEN-1:0] alu_res;
  logic alu_zero, alu_ovf;
  exe_alu #(.XLEN(XLEN), .SHW(SHW)) u_alu (
    .alu_op(alu_op), .a(op1), .b(op2), .shamt(shamt),
    .result(alu_res), .zero(alu_zero), .overflow(alu_ovf)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zero <= 1'b0;
      overflow <= 1'b0;
      branch_target <= '0;
      pc_src <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      result <= alu_res;
      zero <= alu_zero;
      overflow <= alu_ovf;
      branch_target <= pc_plus4 + (ext_imm << 2);
      pc_src <= in_valid & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero));
      out_valid <= in_valid;
    end
  end
endmodule

// File: tb/tb_exe_alu_branch_unit.sv
// tb_exe_alu_branch_unit: directed self-checking bench for exe_alu_branch_unit
module tb_exe_alu_branch_unit;
  import exe_pkg::*;
`ifdef EXE_OVF_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, in_valid, branch_eq, branch_ne;
  logic [31:0] op1, op2, pc_plus4, ext_imm;
  logic [3:0] alu_op;
  logic [4:0] shamt;
  logic [31:0] result, branch_target;
  logic zero, overflow, pc_src, out_valid;
  int n_vec = 0;
  int n_err = 0;

  exe_alu_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op1(op1), .op2(op2),
    .alu_op(alu_op), .shamt(shamt), .pc_plus4(pc_plus4), .ext_imm(ext_imm),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .result(result), .zero(zero),
    .overflow(overflow), .branch_target(branch_target), .pc_src(pc_src),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    alu_op = op;
    op1 = a;
    op2 = b;
    shamt = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    branch_eq = 1'b1;
    branch_ne = 1'b1;
    pc_plus4 = 32'd100;
    ext_imm = 32'd1;
    apply(ALU_ADD, 32'd2, 32'd3, 5'd0);
    n_vec++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_vec++; if (out_valid !== 1'b0 || pc_src !== 1'b0) begin n_err++; $display("FAIL reset_valid_pcsrc got=%b%b exp=00", out_valid, pc_src); end
    n_vec++; if (branch_target !== 32'd0 || zero !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_misc got=%h %b %b exp=0 0 0", branch_target, zero, overflow); end
    rst_n = 1'b1;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    apply(ALU_ADD, 32'd2, 32'd3, 5'd0);
    n_vec++; if (result !== 32'd5 || out_valid !== 1'b1) begin n_err++; $display("FAIL reset_release got=%h v=%b exp=5 v=1", result, out_valid); end
    n_vec++; if (branch_target !== 32'd104) begin n_err++; $display("FAIL reset_release_target got=%h exp=104", branch_target); end
  endtask

  task automatic test_arith;
    apply(ALU_ADD, 32'd5, 32'd10, 5'd0);
    n_vec++; if (result !== 32'd15 || zero !== 1'b0) begin n_err++; $display("FAIL add got=%h z=%b exp=f z=0", result, zero); end
    apply(ALU_SUB, 32'd3, 32'd5, 5'd0);
    n_vec++; if (result !== 32'hFFFF_FFFE || overflow !== 1'b0) begin n_err++; $display("FAIL sub_neg got=%h o=%b exp=fffffffe o=0", result, overflow); end
    apply(ALU_SUB, 32'd7, 32'd7, 5'd0);
    n_vec++; if (result !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got=%h z=%b exp=0 z=1", result, zero); end
    apply(ALU_NOR, 32'hF0F0_0000, 32'h0000_00FF, 5'd0);
    n_vec++; if (result !== 32'h0F0F_FF00) begin n_err++; $display("FAIL nor got=%h exp=0f0fff00", result); end
    apply(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
    n_vec++; if (result !== 32'h5555_5555) begin n_err++; $display("FAIL xor got=%h exp=55555555", result); end
  endtask

  task automatic test_overflow;
    apply(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    n_vec++; if (result !== 32'h8000_0000 || overflow !== OVF_EN) begin n_err++; $display("FAIL add_ovf got=%h o=%b exp=80000000 o=%b", result, overflow, OVF_EN); end
    apply(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0);
    n_vec++; if (result !== 32'h7FFF_FFFF || overflow !== OVF_EN) begin n_err++; $display("FAIL sub_ovf got=%h o=%b exp=7fffffff o=%b", result, overflow, OVF_EN); end
    apply(ALU_OR, 32'h7FFF_FFFF, 32'd1, 5'd0);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL or_no_ovf got=%b exp=0", overflow); end
    apply(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_vec++; if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL add_wrap got=%h z=%b o=%b exp=0 z=1 o=0", result, zero, overflow); end
  endtask

  task automatic test_shift_compare;
    apply(ALU_SLL, 32'd0, 32'd1, 5'd31);
    n_vec++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL sll got=%h exp=80000000", result); end
    apply(ALU_SRA, 32'd0, 32'h8000_0000, 5'd4);
    n_vec++; if (result !== 32'hF800_0000) begin n_err++; $display("FAIL sra got=%h exp=f8000000", result); end
    apply(ALU_SRL, 32'd0, 32'h8000_0000, 5'd4);
    n_vec++; if (result !== 32'h0800_0000) begin n_err++; $display("FAIL srl got=%h exp=08000000", result); end
    apply(ALU_SRL, 32'd0, 32'h1234_5678, 5'd0);
    n_vec++; if (result !== 32'h1234_5678) begin n_err++; $display("FAIL srl0 got=%h exp=12345678", result); end
    apply(ALU_SLLV, 32'hFFFF_FFE3, 32'h0000_0001, 5'd0);
    n_vec++; if (result !== 32'h0000_0008) begin n_err++; $display("FAIL sllv got=%h exp=8", result); end
    apply(ALU_SRAV, 32'd8, 32'h8000_0000, 5'd0);
    n_vec++; if (result !== 32'hFF80_0000) begin n_err++; $display("FAIL srav got=%h exp=ff800000", result); end
    apply(ALU_SRLV, 32'd8, 32'h8000_0000, 5'd3);
    n_vec++; if (result !== 32'h0080_0000) begin n_err++; $display("FAIL srlv got=%h exp=00800000", result); end
    apply(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_vec++; if (result !== 32'd1) begin n_err++; $display("FAIL slt got=%h exp=1", result); end
    apply(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_vec++; if (result !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL sltu got=%h z=%b exp=0 z=1", result, zero); end
    apply(ALU_LUI, 32'd0, 32'hABCD_1234, 5'd0);
    n_vec++; if (result !== 32'h1234_0000) begin n_err++; $display("FAIL lui got=%h exp=12340000", result); end
    apply(ALU_PASSB, 32'h1, 32'hDEAD_BEEF, 5'd0);
    n_vec++; if (result !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL passb got=%h exp=deadbeef", result); end
  endtask

  task automatic test_branch;
    pc_plus4 = 32'd204;
    ext_imm = 32'd3;
    branch_eq = 1'b1;
    apply(ALU_SUB, 32'd5, 32'd5, 5'd0);
    n_vec++; if (branch_target !== 32'd216 || pc_src !== 1'b1) begin n_err++; $display("FAIL beq_taken got=%0d p=%b exp=216 p=1", branch_target, pc_src); end
    ext_imm = 32'hFFFF_FFFF;
    apply(ALU_SUB, 32'd5, 32'd5, 5'd0);
    n_vec++; if (branch_target !== 32'd200 || pc_src !== 1'b1) begin n_err++; $display("FAIL beq_back got=%0d p=%b exp=200 p=1", branch_target, pc_src); end
    apply(ALU_SUB, 32'd5, 32'd3, 5'd0);
    n_vec++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL beq_not_taken got=%b exp=0", pc_src); end
    branch_eq = 1'b0;
    branch_ne = 1'b1;
    apply(ALU_SUB, 32'd5, 32'd5, 5'd0);
    n_vec++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL bne_equal got=%b exp=0", pc_src); end
    apply(ALU_SUB, 32'd5, 32'd3, 5'd0);
    n_vec++; if (pc_src !== 1'b1) begin n_err++; $display("FAIL bne_taken got=%b exp=1", pc_src); end
    in_valid = 1'b0;
    apply(ALU_SUB, 32'd5, 32'd3, 5'd0);
    n_vec++; if (pc_src !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL invalid got=p%b v%b exp=p0 v0", pc_src, out_valid); end
    n_vec++; if (result !== 32'd2 || branch_target !== 32'd200) begin n_err++; $display("FAIL invalid_data got=%h %0d exp=2 200", result, branch_target); end
    in_valid = 1'b1;
    branch_ne = 1'b0;
    apply(ALU_ADD, 32'd0, 32'd0, 5'd0);
    n_vec++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL no_branch got=%b exp=0", pc_src); end
  endtask

  task automatic test_back_to_back;
    ext_imm = 32'd0;
    alu_op = ALU_ADD; op1 = 32'd1; op2 = 32'd2;
    @(posedge clk); #1;
    n_vec++; if (result !== 32'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_add got=%h v=%b exp=3 v=1", result, out_valid); end
    alu_op = ALU_SUB; op1 = 32'd10; op2 = 32'd4;
    @(posedge clk); #1;
    n_vec++; if (result !== 32'd6 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_sub got=%h v=%b exp=6 v=1", result, out_valid); end
    alu_op = ALU_AND; op1 = 32'h0000_F0F0; op2 = 32'h0000_FF00;
    @(posedge clk); #1;
    n_vec++; if (result !== 32'h0000_F000 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_and got=%h v=%b exp=f000 v=1", result, out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0;
    op1 = '0; op2 = '0; alu_op = '0; shamt = '0; pc_plus4 = '0; ext_imm = '0;
    @(posedge clk); #1;
    test_reset;
    test_arith;
    test_overflow;
    test_shift_compare;
    test_branch;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
